// File: rtl/systolic_pkg.sv
// systolic_pkg - shared constants and types for the systolic array and its weight loader.
// Rev 1.0 - initial release.
`default_nettype none

package systolic_pkg;

  localparam int unsigned c_DATA_SIZE = 32;
  localparam int unsigned c_ROWS      = 4;
  localparam int unsigned c_COLS      = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } wl_state_t;

  // Index width for an n-entry structure; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_weight_buf.sv
// systolic_weight_buf - ROWS-deep row-vector register file, one write port, one combinational read port.
// Rev 1.0 - initial release.
`default_nettype none

module systolic_weight_buf
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE = c_DATA_SIZE,
  parameter int ROWS      = c_ROWS,
  parameter int COLS      = c_COLS,
  localparam int IW       = idx_width(ROWS)
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [IW-1:0]             i_widx,
  input  logic [COLS*DATA_SIZE-1:0] i_wdata,
  input  logic [IW-1:0]             i_ridx,
  output logic [COLS*DATA_SIZE-1:0] o_rdata
);

  // Contents are intentionally not reset; a tile is always fully rewritten before a burst.
  logic [COLS*DATA_SIZE-1:0] r_mem [ROWS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

`default_nettype wire

// File: rtl/systolic_weight_loader.sv
// systolic_weight_loader - buffers a ROWS x COLS weight tile, then bursts it into the PE array in reverse row order.
// Rev 1.0 - initial release.
`default_nettype none

module systolic_weight_loader
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE = c_DATA_SIZE,
  parameter int ROWS      = c_ROWS,
  parameter int COLS      = c_COLS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [COLS*DATA_SIZE-1:0] w_data,
  output logic [ROWS-1:0]           ld_weight,
  output logic [COLS*DATA_SIZE-1:0] col_sum,
  output logic                      array_en,
  output logic                      busy,
  output logic                      load_done
);

  localparam int            IW     = idx_width(ROWS);
  localparam logic [IW-1:0] c_LAST = IW'(ROWS - 1);

  wl_state_t                 r_state;
  wl_state_t                 w_state_nxt;
  logic [IW-1:0]             r_widx;
  logic [IW-1:0]             r_bcnt;
  logic [IW-1:0]             w_ridx;
  logic                      r_w_ready;
  logic                      w_wr;
  logic [COLS*DATA_SIZE-1:0] w_rdata;

  assign w_wr    = w_valid && r_w_ready;
  assign w_ready = r_w_ready;
  // Last buffered row goes out first so row r ends up latching buf[r].
  assign w_ridx  = c_LAST - r_bcnt;

  systolic_weight_buf #(
    .DATA_SIZE (DATA_SIZE),
    .ROWS      (ROWS),
    .COLS      (COLS)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_wr),
    .i_widx  (r_widx),
    .i_wdata (w_data),
    .i_ridx  (w_ridx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ld_weight   = '0;
    col_sum     = '0;
    array_en    = 1'b0;
    load_done   = 1'b0;
    busy        = (r_state != FILL) || (r_widx != '0);
    case (r_state)
      FILL: begin
        if (w_wr && (r_widx == c_LAST)) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        ld_weight = '1;
        col_sum   = w_rdata;
        array_en  = 1'b1;
        if (r_bcnt == c_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        load_done   = 1'b1;
        w_state_nxt = FILL;
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // w_ready is registered from the next state so it stays low through the reset cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_widx    <= '0;
      r_bcnt    <= '0;
      r_w_ready <= 1'b0;
    end else begin
      r_w_ready <= (w_state_nxt == FILL);
      if (w_wr) begin
        r_widx <= (r_widx == c_LAST) ? '0 : r_widx + 1'b1;
      end
      if (r_state == LOAD) begin
        r_bcnt <= (r_bcnt == c_LAST) ? '0 : r_bcnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_weight_loader.sv
// tb_systolic_weight_loader - directed bench for the weight loader with a 4x4 PE weight-chain model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_systolic_weight_loader;

  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           w_valid;
  logic           w_ready;
  logic [4*DW-1:0] w_data;
  logic [3:0]     ld_weight;
  logic [4*DW-1:0] col_sum;
  logic           array_en, busy, load_done;

  logic           w_valid1;
  logic           w_ready1;
  logic [2*DW-1:0] w_data1;
  logic [0:0]     ld_weight1;
  logic [2*DW-1:0] col_sum1;
  logic           array_en1, busy1, load_done1;

  int n_tests = 0;
  int n_fail  = 0;

  // Status bundle: {ld_weight, array_en, w_ready, busy, load_done}
  logic [7:0] st;
  logic [4:0] st1;
  assign st  = {ld_weight, array_en, w_ready, busy, load_done};
  assign st1 = {ld_weight1, array_en1, w_ready1, busy1, load_done1};

  localparam logic [7:0] ST_RST  = 8'b0000_0_0_0_0;
  localparam logic [7:0] ST_IDLE = 8'b0000_0_1_0_0;
  localparam logic [7:0] ST_FILL = 8'b0000_0_1_1_0;
  localparam logic [7:0] ST_LOAD = 8'b1111_1_0_1_0;
  localparam logic [7:0] ST_DONE = 8'b0000_0_0_1_1;

  always #5 clk = ~clk;

  systolic_weight_loader #(.DATA_SIZE(DW), .ROWS(4), .COLS(4)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .ld_weight(ld_weight), .col_sum(col_sum), .array_en(array_en), .busy(busy),
    .load_done(load_done)
  );

  systolic_weight_loader #(.DATA_SIZE(DW), .ROWS(1), .COLS(2)) dut1 (
    .clk(clk), .reset(reset), .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1),
    .ld_weight(ld_weight1), .col_sum(col_sum1), .array_en(array_en1), .busy(busy1),
    .load_done(load_done1)
  );

  // PE weight-shift chain: weight <= in_sum; out_sum <= in_sum while loading.
  logic [DW-1:0] pe_w [4][4];
  logic [DW-1:0] pe_o [4][4];
  always @(posedge clk) begin
    if (array_en) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (ld_weight[r]) begin
            if (r == 0) begin
              pe_w[r][c] <= col_sum[c*DW +: DW];
              pe_o[r][c] <= col_sum[c*DW +: DW];
            end else begin
              pe_w[r][c] <= pe_o[r-1][c];
              pe_o[r][c] <= pe_o[r-1][c];
            end
          end
        end
      end
    end
  end

  function automatic logic [4*DW-1:0] exp_row(input int base, input int r);
    logic [4*DW-1:0] v;
    for (int c = 0; c < 4; c++) v[c*DW +: DW] = DW'(base + 16*r + c);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    n_tests++;
    if (st !== ST_RST) begin
      n_fail++; $display("FAIL reset_status: got %b expected %b", st, ST_RST);
    end
    n_tests++;
    if (col_sum !== '0) begin
      n_fail++; $display("FAIL reset_col_sum: got %h expected 0", col_sum);
    end
    n_tests++;
    if (st1 !== 5'b0) begin
      n_fail++; $display("FAIL reset_status_r1: got %b expected 00000", st1);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (st !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", st, ST_IDLE);
    end
  endtask

  task automatic test_basic_tile;
    for (int r = 0; r < 4; r++) begin
      w_valid = 1'b1; w_data = exp_row(0, r);
      n_tests++;
      if (st !== ((r == 0) ? ST_IDLE : ST_FILL)) begin
        n_fail++; $display("FAIL basic_fill_r%0d: got %b", r, st);
      end
      tick();
    end
    w_valid = 1'b0; w_data = '0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (st !== ST_LOAD || col_sum !== exp_row(0, 3 - k)) begin
        n_fail++; $display("FAIL basic_burst_k%0d: got st=%b sum=%h expected st=%b sum=%h",
                           k, st, col_sum, ST_LOAD, exp_row(0, 3 - k));
      end
      tick();
    end
    n_tests++;
    if (st !== ST_DONE || col_sum !== '0) begin
      n_fail++; $display("FAIL basic_done: got st=%b sum=%h expected st=%b sum=0", st, col_sum, ST_DONE);
    end
    tick();
    n_tests++;
    if (st !== ST_IDLE) begin
      n_fail++; $display("FAIL basic_ready_again: got %b expected %b", st, ST_IDLE);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if (pe_w[r][c] !== DW'(16*r + c)) begin
          n_fail++; $display("FAIL basic_pe_%0d_%0d: got %0d expected %0d", r, c, pe_w[r][c], 16*r + c);
        end
      end
    end
  endtask

  task automatic test_bubbled;
    for (int r = 0; r < 4; r++) begin
      w_valid = 1'b1; w_data = exp_row(256, r);
      n_tests++;
      if (st !== ((r == 0) ? ST_IDLE : ST_FILL)) begin
        n_fail++; $display("FAIL bubble_fill_r%0d: got %b", r, st);
      end
      tick();
      if (r < 3) begin
        w_valid = 1'b0; w_data = {4{32'hDEAD_BEEF}};
        for (int g = 0; g < 2; g++) begin
          n_tests++;
          if (st !== ST_FILL) begin
            n_fail++; $display("FAIL bubble_gap_r%0d_g%0d: got %b expected %b", r, g, st, ST_FILL);
          end
          tick();
        end
      end
    end
    w_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (st !== ST_LOAD || col_sum !== exp_row(256, 3 - k)) begin
        n_fail++; $display("FAIL bubble_burst_k%0d: got st=%b sum=%h expected sum=%h",
                           k, st, col_sum, exp_row(256, 3 - k));
      end
      tick();
    end
    n_tests++;
    if (st !== ST_DONE) begin
      n_fail++; $display("FAIL bubble_done: got %b expected %b", st, ST_DONE);
    end
    tick();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if (pe_w[r][c] !== DW'(256 + 16*r + c)) begin
          n_fail++; $display("FAIL bubble_pe_%0d_%0d: got %0d expected %0d", r, c, pe_w[r][c], 256 + 16*r + c);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    for (int r = 0; r < 4; r++) begin
      w_valid = 1'b1; w_data = exp_row(512, r);
      tick();
    end
    // Next tile's row 0 held valid through LOAD/DONE must not be written.
    w_data = exp_row(768, 0);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (st !== ST_LOAD || col_sum !== exp_row(512, 3 - k)) begin
        n_fail++; $display("FAIL bp_burst_k%0d: got st=%b sum=%h expected sum=%h",
                           k, st, col_sum, exp_row(512, 3 - k));
      end
      tick();
    end
    n_tests++;
    if (st !== ST_DONE) begin
      n_fail++; $display("FAIL bp_done: got %b expected %b", st, ST_DONE);
    end
    tick();
    n_tests++;
    if (st !== ST_IDLE) begin
      n_fail++; $display("FAIL bp_accept_at_T6: got %b expected %b", st, ST_IDLE);
    end
    tick();
    for (int r = 1; r < 4; r++) begin
      w_data = exp_row(768, r);
      n_tests++;
      if (st !== ST_FILL) begin
        n_fail++; $display("FAIL bp_fill2_r%0d: got %b expected %b", r, st, ST_FILL);
      end
      tick();
    end
    w_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (st !== ST_LOAD || col_sum !== exp_row(768, 3 - k)) begin
        n_fail++; $display("FAIL bp_burst2_k%0d: got st=%b sum=%h expected sum=%h",
                           k, st, col_sum, exp_row(768, 3 - k));
      end
      tick();
    end
    tick();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if (pe_w[r][c] !== DW'(768 + 16*r + c)) begin
          n_fail++; $display("FAIL bp_pe_%0d_%0d: got %0d expected %0d", r, c, pe_w[r][c], 768 + 16*r + c);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    for (int r = 0; r < 4; r++) begin
      w_valid = 1'b1; w_data = exp_row(1024, r);
      tick();
    end
    w_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if (st !== ST_LOAD || col_sum !== exp_row(1024, 1)) begin
      n_fail++; $display("FAIL rstb_burst_k2: got st=%b sum=%h expected sum=%h", st, col_sum, exp_row(1024, 1));
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (st !== ST_RST || col_sum !== '0) begin
      n_fail++; $display("FAIL rstb_abort: got st=%b sum=%h expected st=%b sum=0", st, col_sum, ST_RST);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (st !== ST_IDLE) begin
      n_fail++; $display("FAIL rstb_release: got %b expected %b", st, ST_IDLE);
    end
    for (int r = 0; r < 4; r++) begin
      w_valid = 1'b1; w_data = exp_row(1280, r);
      tick();
    end
    w_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (st !== ST_LOAD || col_sum !== exp_row(1280, 3 - k)) begin
        n_fail++; $display("FAIL rstb_burst2_k%0d: got st=%b sum=%h expected sum=%h",
                           k, st, col_sum, exp_row(1280, 3 - k));
      end
      tick();
    end
    tick();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if (pe_w[r][c] !== DW'(1280 + 16*r + c)) begin
          n_fail++; $display("FAIL rstb_pe_%0d_%0d: got %0d expected %0d", r, c, pe_w[r][c], 1280 + 16*r + c);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill;
    for (int r = 0; r < 2; r++) begin
      w_valid = 1'b1; w_data = exp_row(1536, r);
      tick();
    end
    w_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if (st !== ST_IDLE) begin
      n_fail++; $display("FAIL rstf_release: got %b expected %b", st, ST_IDLE);
    end
    for (int r = 0; r < 4; r++) begin
      w_valid = 1'b1; w_data = exp_row(1792, r);
      tick();
    end
    w_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (st !== ST_LOAD || col_sum !== exp_row(1792, 3 - k)) begin
        n_fail++; $display("FAIL rstf_burst_k%0d: got st=%b sum=%h expected sum=%h",
                           k, st, col_sum, exp_row(1792, 3 - k));
      end
      tick();
    end
    n_tests++;
    if (st !== ST_DONE) begin
      n_fail++; $display("FAIL rstf_done: got %b expected %b", st, ST_DONE);
    end
    tick();
  endtask

  task automatic test_single_row;
    w_valid1 = 1'b1; w_data1 = {32'd7, 32'd5};
    n_tests++;
    if (st1 !== 5'b0_0_1_0_0) begin
      n_fail++; $display("FAIL r1_idle: got %b expected 00100", st1);
    end
    tick();
    w_valid1 = 1'b0; w_data1 = '0;
    n_tests++;
    if (st1 !== 5'b1_1_0_1_0 || col_sum1 !== {32'd7, 32'd5}) begin
      n_fail++; $display("FAIL r1_load: got st=%b sum=%h expected st=11010 sum=%h", st1, col_sum1, {32'd7, 32'd5});
    end
    tick();
    n_tests++;
    if (st1 !== 5'b0_0_0_1_1 || col_sum1 !== '0) begin
      n_fail++; $display("FAIL r1_done: got st=%b sum=%h expected st=00011 sum=0", st1, col_sum1);
    end
    tick();
    n_tests++;
    if (st1 !== 5'b0_0_1_0_0) begin
      n_fail++; $display("FAIL r1_ready_again: got %b expected 00100", st1);
    end
  endtask

  initial begin
    reset = 1'b0; w_valid = 1'b0; w_data = '0;
    w_valid1 = 1'b0; w_data1 = '0;
    test_reset();
    test_basic_tile();
    test_bubbled();
    test_backpressure();
    test_reset_mid_burst();
    test_reset_mid_fill();
    test_single_row();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
